cover_toggle_collector: RTL
===========================

Name: cover_toggle_collector

Overview:
- Parametrised toggle-coverage collector, successor to the fixed-width per-bit coverage generators.
- Takes a WIDTH-bit vector of toggle-valid strobes and records a sticky hit per bit.
- Each bit's first hit is reported exactly once as a global cover index (COVER_INDEX + bit) over a valid/ready stream, lossless under backpressure.
- Keeps a running hit count. Sits between instrumented RTL and the coverage sink (DPI bridge or formal harness).

Parameters:
- WIDTH, 13: number of toggle points monitored (1..1024).
- COVER_INDEX, 0: global index of bit 0.
- COVER_TOTAL, 38253: total points in design. Elaboration check: COVER_INDEX+WIDTH <= COVER_TOTAL.
- IDX_W, 32: width of out_index.
- CNT_W, $clog2(WIDTH+1): width of hit_count.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  collection enable; valid ignored when 0.
- clear  in  1  synchronous clear of all coverage state.
- valid  in  WIDTH  per-bit toggle strobe, sampled each cycle.
- out_valid  out  1  a first-hit index is presented.
- out_ready  in  1  sink accepts out_index this cycle.
- out_index  out  IDX_W  COVER_INDEX + bit number of the reported first hit.
- hit_map  out  WIDTH  sticky per-bit hit record.
- hit_count  out  CNT_W  popcount of hit_map, registered.
- all_hit  out  1  hit_count == WIDTH.

Behaviour:
- Reset (async assert, sync deassert by the integrator) drives all registers to 0: hit_map, pending, out_valid, out_index, hit_count, all_hit.
- Capture: new = valid & ~hit_map when en=1, else 0.
  - Next cycle: hit_map |= new; pending |= new.
  - Repeated hits on an already-set bit produce nothing.
- Output stage is a single registered slot.
  - Load condition: out_valid==0, or out_valid && out_ready.
  - When the load condition holds and pending != 0: select the lowest set pending bit b, set out_index = COVER_INDEX + b and out_valid = 1, and clear pending[b] in the same edge.
  - When the load condition holds and pending == 0: out_valid becomes 0.
  - Accept and reload on the same edge is required, sustaining one report per cycle.
- Latency: valid[b] at edge N gives hit_map[b]=1 after edge N. With an idle output, out_valid=1 with index b after edge N+1 (2 cycles).
- Handshake: while out_valid=1 && out_ready=0, out_valid and out_index hold stable. The pending vector buffers all other first hits, so nothing is dropped and no index is reported twice.
- hit_count and all_hit are updated one cycle after hit_map changes. CNT_W must hold WIDTH without wrap.
- Clear has priority over capture in the same cycle: valid that cycle is ignored. Clear zeroes hit_map, pending, out_valid and hit_count. A transfer accepted in the clear cycle completes and is not re-presented.
- Reset mid-stream discards pending reports and out_valid immediately; no partial state survives.
- en=0 freezes capture only. Draining of pending and output continues.
- The bridge DPI call and the formal cover property are not part of this block; this block is synthesizable.

Test Plan:
- Reset then valid=13'h0005 for 1 cycle, out_ready=1 -> out_index 0 then 2 on consecutive cycles (COVER_INDEX=0); hit_map=0x0005; hit_count=2.
- out_ready=0, valid=13'h1FFF held 3 cycles -> out_valid=1, out_index=0 stable. Then out_ready=1 -> indices 0..12 on 13 consecutive cycles, each once; all_hit=1.
- COVER_INDEX=1000, valid[7] pulsed twice 5 cycles apart -> exactly one report, out_index=1007.
- clear asserted with valid=13'h0010 in the same cycle -> hit_map=0, no report for bit 4. valid[4] the next cycle -> report 4.
- en=0 with valid=all ones -> hit_map stays 0, out_valid stays 0. Pending entries from before en fell still drain.
- reset asserted asynchronously mid-stream with 5 pending -> out_valid drops without a clock edge. After release, no stale indices appear.

Source files
------------

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector
//   Toggle-coverage collector. Records a sticky hit per monitored bit and
//   reports each bit's first hit exactly once as a global cover index
//   (COVER_INDEX + bit) over a valid/ready stream. Reports are never lost
//   under backpressure. Also keeps a registered running hit count.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   en         in   collection enable; valid ignored when low
//   clear      in   synchronous clear of all coverage state
//   valid      in   [WIDTH]  per-bit toggle strobe
//   out_valid  out  a first-hit index is presented
//   out_ready  in   sink accepts out_index this cycle
//   out_index  out  [IDX_W]  COVER_INDEX + bit number of the reported hit
//   hit_map    out  [WIDTH]  sticky per-bit hit record
//   hit_count  out  [CNT_W]  registered popcount of hit_map
//   all_hit    out  hit_count == WIDTH
module cover_toggle_collector #(
  parameter int unsigned WIDTH       = 13,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 38253,
  parameter int unsigned IDX_W       = 32,
  parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [WIDTH-1:0] hit_map,
  output logic [CNT_W-1:0] hit_count,
  output logic             all_hit
);

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
    $error("cover_toggle_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] hit_map_q, hit_map_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             all_hit_q, all_hit_d;

  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] sel_mask;
  logic             sel_found;
  int unsigned      sel_bit;
  logic             load;
  logic [CNT_W-1:0] pop;

  always_comb begin
    new_hits = en ? (valid & ~hit_map_q) : '0;
    // Output slot may take a new entry when empty or being drained this edge.
    load = !out_valid_q || out_ready;

    // Lowest set pending bit, as a one-hot mask and a bit number.
    sel_found = 1'b0;
    sel_bit   = 0;
    sel_mask  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!sel_found && pending_q[i]) begin
        sel_found   = 1'b1;
        sel_bit     = i;
        sel_mask[i] = 1'b1;
      end
    end

    // Count is taken from the registered map, so it lags hit_map by a cycle.
    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + CNT_W'(hit_map_q[i]);
    end

    hit_map_d   = hit_map_q | new_hits;
    pending_d   = pending_q | new_hits;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    hit_count_d = pop;
    all_hit_d   = (pop == CNT_W'(WIDTH));

    if (load) begin
      out_valid_d = sel_found;
      if (sel_found) begin
        out_index_d = IDX_W'(COVER_INDEX + sel_bit);
        pending_d   = pending_d & ~sel_mask;
      end
    end

    // Clear wins over capture; an entry accepted this edge is simply dropped
    // from the slot rather than re-presented.
    if (clear) begin
      hit_map_d   = '0;
      pending_d   = '0;
      out_valid_d = 1'b0;
      hit_count_d = '0;
      all_hit_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_map_q   <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      hit_count_q <= '0;
      all_hit_q   <= 1'b0;
    end else begin
      hit_map_q   <= hit_map_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      hit_count_q <= hit_count_d;
      all_hit_q   <= all_hit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign hit_map   = hit_map_q;
  assign hit_count = hit_count_q;
  assign all_hit   = all_hit_q;

endmodule
